// File: rtl/pwm_gen_if.sv
// pwm_gen_if: signal bundle between the timer peripheral (counter and
// register file) and the pwm_gen output stage.
//
// Optional feature macro: PWM_COMPLEMENT_EN adds deadtime and pwm_out_n.
//
// Modports:
//   master - timer/register-file side: drives count, period, direction,
//            enable, staging compares, mode, polarity and update; observes
//            the PWM outputs and status.
//   slave  - pwm_gen side: the mirror image of master.
//
// Signals:
//   count_val[15:0]   running counter value
//   period[15:0]      counter period
//   upnotdown         counter direction (0 = up, 1 = down)
//   en                PWM enable
//   compare1[15:0]    first compare value (staging)
//   compare2[15:0]    second compare value (staging, range mode)
//   align_mode[1:0]   0 = left, 1 = right, 2 = range, 3 = reserved
//   invert            output polarity (staging)
//   update            one-cycle shadow reload request
//   pwm_out           PWM output
//   period_end        one-cycle pulse after each period boundary
//   update_pending    reload requested but not yet applied
//   deadtime[7:0]     dead-time cycles (PWM_COMPLEMENT_EN only)
//   pwm_out_n         complementary output (PWM_COMPLEMENT_EN only)
interface pwm_gen_if;
  logic [15:0] count_val;
  logic [15:0] period;
  logic        upnotdown;
  logic        en;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [1:0]  align_mode;
  logic        invert;
  logic        update;
  logic        pwm_out;
  logic        period_end;
  logic        update_pending;
`ifdef PWM_COMPLEMENT_EN
  logic [7:0]  deadtime;
  logic        pwm_out_n;

  modport master (
    output count_val, period, upnotdown, en, compare1, compare2,
           align_mode, invert, update, deadtime,
    input  pwm_out, period_end, update_pending, pwm_out_n
  );

  modport slave (
    input  count_val, period, upnotdown, en, compare1, compare2,
           align_mode, invert, update, deadtime,
    output pwm_out, period_end, update_pending, pwm_out_n
  );
`else
  modport master (
    output count_val, period, upnotdown, en, compare1, compare2,
           align_mode, invert, update,
    input  pwm_out, period_end, update_pending
  );

  modport slave (
    input  count_val, period, upnotdown, en, compare1, compare2,
           align_mode, invert, update,
    output pwm_out, period_end, update_pending
  );
`endif
endinterface

// File: rtl/pwm_gen.sv
// pwm_gen: PWM output stage driven by the timer counter value.
//
// Compares the running count against double-buffered (shadowed) compare
// values and drives a registered PWM waveform. Shadows reload only at the
// counter period boundary so configuration changes never produce runt
// pulses.
//
// Optional feature macro: PWM_COMPLEMENT_EN adds a complementary output
// with an 8-bit dead-time counter.
//
// Ports:
//   clk    peripheral clock
//   rst_n  asynchronous active-low reset
//   bus    pwm_gen_if.slave (count/config inputs, pwm/status outputs)
module pwm_gen (
  input  logic      clk,
  input  logic      rst_n,
  pwm_gen_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [15:0] prev_cnt_reg;
  logic [15:0] c1_reg, c2_reg;
  logic [1:0]  mode_reg;
  logic        inv_reg;
  logic        pending_reg, pending_next;
  logic        period_end_reg, period_end_next;
  logic        pwm_reg, pwm_next;
  logic        load;

  logic [15:0] start_val;
  logic        boundary;
  logic [15:0] c1_eff, c2_eff;
  logic [1:0]  mode_eff;
  logic        inv_eff;
  logic        raw;
  logic        level_next;
  logic        run_next;

  // A boundary is the count arriving at its start value; requiring a change
  // from last cycle keeps a stalled counter from re-triggering it.
  always_comb begin
    start_val = bus.upnotdown ? (bus.period - 16'd1) : 16'd0;
    boundary  = (bus.count_val != prev_cnt_reg) && (bus.count_val == start_val);
  end

  // FSM next-state and control decode.
  always_comb begin
    state_next      = state_reg;
    load            = 1'b0;
    pending_next    = pending_reg;
    period_end_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        pending_next = 1'b0;
        if (bus.en) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en) begin
          // Disable takes priority over a coincident boundary.
          state_next   = IDLE;
          pending_next = 1'b0;
        end else if (boundary) begin
          period_end_next = 1'b1;
          pending_next    = 1'b0;
          load            = pending_reg | bus.update;
        end else if (bus.update) begin
          pending_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // In a load cycle the staging values bypass the shadows so the first
  // compare of the new period already uses them.
  always_comb begin
    c1_eff   = load ? bus.compare1   : c1_reg;
    c2_eff   = load ? bus.compare2   : c2_reg;
    mode_eff = load ? bus.align_mode : mode_reg;
    inv_eff  = load ? bus.invert     : inv_reg;
  end

  always_comb begin
    raw = 1'b0;
    unique case (mode_eff)
      2'd0:    raw = (bus.count_val < c1_eff);
      2'd1:    raw = (bus.count_val >= c1_eff);
      2'd2:    raw = (c1_eff < c2_eff) && (bus.count_val >= c1_eff) &&
                     (bus.count_val < c2_eff);
      default: raw = 1'b0;
    endcase
    level_next = raw ^ inv_eff;
    run_next   = (state_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      prev_cnt_reg   <= 16'd0;
      c1_reg         <= 16'd0;
      c2_reg         <= 16'd0;
      mode_reg       <= 2'd0;
      inv_reg        <= 1'b0;
      pending_reg    <= 1'b0;
      period_end_reg <= 1'b0;
      pwm_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_cnt_reg   <= bus.count_val;
      pending_reg    <= pending_next;
      period_end_reg <= period_end_next;
      pwm_reg        <= pwm_next;
      if (load) begin
        c1_reg   <= bus.compare1;
        c2_reg   <= bus.compare2;
        mode_reg <= bus.align_mode;
        inv_reg  <= bus.invert;
      end
    end
  end

`ifdef PWM_COMPLEMENT_EN
  logic       level_reg;
  logic [7:0] dcnt_reg, dcnt_next;
  logic       pwm_n_reg, pwm_n_next;

  // Every level change restarts the dead window; neither output may assert
  // until it has fully expired.
  always_comb begin
    if (level_next != level_reg)
      dcnt_next = bus.deadtime;
    else if (dcnt_reg != 8'd0)
      dcnt_next = dcnt_reg - 8'd1;
    else
      dcnt_next = 8'd0;
    pwm_next   = run_next &  level_next & (dcnt_next == 8'd0);
    pwm_n_next = run_next & ~level_next & (dcnt_next == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= 1'b0;
      dcnt_reg  <= 8'd0;
      pwm_n_reg <= 1'b0;
    end else begin
      level_reg <= level_next;
      dcnt_reg  <= dcnt_next;
      pwm_n_reg <= pwm_n_next;
    end
  end

  assign bus.pwm_out_n = pwm_n_reg;
`else
  always_comb begin
    pwm_next = run_next & level_next;
  end
`endif

  assign bus.pwm_out        = pwm_reg;
  assign bus.period_end     = period_end_reg;
  assign bus.update_pending = pending_reg;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen. A behavioural model predicts
// every registered output each cycle; table vectors and hand sequences add
// per-period waveform checks.
module tb_pwm_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_gen_if bus ();

  pwm_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (what the outputs should show after the next edge)
  bit          m_run, m_pend, m_level, e_pwm, e_pwm_n, e_pe;
  logic [15:0] m_prev, m_c1, m_c2;
  logic [1:0]  m_mode;
  bit          m_inv;
  int          m_dcnt;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] c1;
    logic [15:0] c2;
    bit          inv;
    bit          dn;
    int          exp_high;
  } vec_t;

  task automatic report(input string name, input int act, input int exp);
    n_bad++;
    if (n_bad <= 40)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) report(name, int'(act), int'(exp));
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) report(name, act, exp);
  endtask

  function automatic bit spec_level(input logic [15:0] cnt, input logic [15:0] c1,
                                    input logic [15:0] c2, input logic [1:0] mode,
                                    input bit inv);
    bit hi;
    case (mode)
      2'd0:    hi = (c1 > cnt);
      2'd1:    hi = !(c1 > cnt);
      2'd2:    hi = (c1 < c2) && (cnt >= c1) && (cnt < c2);
      default: hi = 1'b0;
    endcase
    return hi ^ inv;
  endfunction

  function automatic logic [15:0] next_count(input logic [15:0] c);
    if (!bus.upnotdown)
      return (int'(c) + 1 >= int'(bus.period)) ? 16'd0 : c + 16'd1;
    else
      return (c == 16'd0 || c >= bus.period) ? bus.period - 16'd1 : c - 16'd1;
  endfunction

  function automatic logic [15:0] start_of_period();
    return bus.upnotdown ? bus.period - 16'd1 : 16'd0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_level = 0; m_dcnt = 0;
    e_pwm = 0; e_pwm_n = 0; e_pe = 0;
    m_prev = 16'd0; m_c1 = 16'd0; m_c2 = 16'd0; m_mode = 2'd0; m_inv = 0;
  endtask

  task automatic take_staging();
    m_c1 = bus.compare1; m_c2 = bus.compare2;
    m_mode = bus.align_mode; m_inv = bus.invert;
  endtask

  // Applies the rules to the inputs of the current cycle.
  task automatic model_step();
    bit bnd, lvl;
    bnd  = (bus.count_val != m_prev) && (bus.count_val == start_of_period());
    e_pe = 0;
    if (!m_run) begin
      m_pend = 0;
      if (bus.en) begin m_run = 1; take_staging(); end
    end else if (!bus.en) begin
      m_run = 0; m_pend = 0;
    end else if (bnd) begin
      if (m_pend || bus.update) take_staging();
      m_pend = 0; e_pe = 1;
    end else if (bus.update) begin
      m_pend = 1;
    end
    lvl = spec_level(bus.count_val, m_c1, m_c2, m_mode, m_inv);
`ifdef PWM_COMPLEMENT_EN
    if (lvl != m_level) m_dcnt = int'(bus.deadtime);
    else if (m_dcnt > 0) m_dcnt--;
    m_level = lvl;
    e_pwm   = m_run && lvl && (m_dcnt == 0);
    e_pwm_n = m_run && !lvl && (m_dcnt == 0);
`else
    e_pwm = m_run && lvl;
`endif
    m_prev = bus.count_val;
  endtask

  // One clock: predict, pass the edge, compare, advance the counter.
  task automatic cycle();
    model_step();
    @(negedge clk);
    check_bit("pwm_out", bus.pwm_out, e_pwm);
    check_bit("period_end", bus.period_end, e_pe);
    check_bit("update_pending", bus.update_pending, m_pend);
`ifdef PWM_COMPLEMENT_EN
    check_bit("pwm_out_n", bus.pwm_out_n, e_pwm_n);
`endif
    bus.count_val = next_count(bus.count_val);
    bus.update = 1'b0;
  endtask

  task automatic align();
    int guard = 0;
    while (bus.count_val != start_of_period() && guard < 100) begin
      cycle();
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      report("align_timeout", guard, 100);
    end
  endtask

  // One full period from the start value; sample i reflects count i.
  task automatic run_period(input int upd_at, input logic [15:0] new_c1,
                            output int highs, output int pends, output int pes,
                            output logic [31:0] pat, output logic [31:0] pat_n);
    highs = 0; pends = 0; pes = 0; pat = '0; pat_n = '0;
    for (int i = 0; i < int'(bus.period); i++) begin
      if (i == upd_at) begin bus.compare1 = new_c1; bus.update = 1'b1; end
      cycle();
      highs += int'(bus.pwm_out);
      pends += int'(bus.update_pending);
      pes   += int'(bus.period_end);
      pat[i] = bus.pwm_out;
`ifdef PWM_COMPLEMENT_EN
      pat_n[i] = bus.pwm_out_n;
`endif
    end
  endtask

  task automatic configure(input logic [1:0] mode, input logic [15:0] c1,
                           input logic [15:0] c2, input bit inv, input bit dn);
    bus.en = 1'b0;
    cycle(); cycle();
    bus.align_mode = mode; bus.compare1 = c1; bus.compare2 = c2;
    bus.invert = inv; bus.upnotdown = dn; bus.period = 16'd10;
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    align();
  endtask

  initial begin
    vec_t        vt[10];
    int          h, p, e;
    logic [31:0] pat, pat_n;

    vt[0] = '{2'd0, 16'd4,  16'd0, 1'b0, 1'b0, 4};
    vt[1] = '{2'd0, 16'd0,  16'd0, 1'b0, 1'b0, 0};
    vt[2] = '{2'd0, 16'd10, 16'd0, 1'b0, 1'b0, 10};
    vt[3] = '{2'd0, 16'd4,  16'd0, 1'b1, 1'b0, 6};
    vt[4] = '{2'd2, 16'd2,  16'd6, 1'b0, 1'b1, 4};
    vt[5] = '{2'd1, 16'd3,  16'd0, 1'b0, 1'b0, 7};
    vt[6] = '{2'd2, 16'd6,  16'd2, 1'b0, 1'b0, 0};
    vt[7] = '{2'd3, 16'd2,  16'd8, 1'b0, 1'b0, 0};
    vt[8] = '{2'd0, 16'd4,  16'd0, 1'b0, 1'b1, 4};
    vt[9] = '{2'd1, 16'd0,  16'd0, 1'b0, 1'b0, 10};

    rst_n = 1'b0;
    bus.count_val = 16'd0; bus.period = 16'd10; bus.upnotdown = 1'b0;
    bus.en = 1'b0; bus.compare1 = 16'd0; bus.compare2 = 16'd0;
    bus.align_mode = 2'd0; bus.invert = 1'b0; bus.update = 1'b0;
`ifdef PWM_COMPLEMENT_EN
    bus.deadtime = 8'd0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_bit("reset_pwm_out", bus.pwm_out, 1'b0);
    check_bit("reset_period_end", bus.period_end, 1'b0);
    check_bit("reset_pending", bus.update_pending, 1'b0);
    rst_n = 1'b1;

    // Table vectors: high cycles and period_end count over one period.
    for (int v = 0; v < 10; v++) begin
      configure(vt[v].mode, vt[v].c1, vt[v].c2, vt[v].inv, vt[v].dn);
      run_period(-1, 16'd0, h, p, e, pat, pat_n);
      $display("vec %0d: mode=%0d c1=%0d c2=%0d inv=%0d dn=%0d highs=%0d pe=%0d",
               v, vt[v].mode, vt[v].c1, vt[v].c2, vt[v].inv, vt[v].dn, h, e);
      check_int($sformatf("vec%0d_highs", v), h, vt[v].exp_high);
      check_int($sformatf("vec%0d_period_end", v), e, 1);
    end

    // Update mid-period: current period keeps c1=4, next one uses 7.
    configure(2'd0, 16'd4, 16'd0, 1'b0, 1'b0);
    run_period(2, 16'd7, h, p, e, pat, pat_n);
    $display("update period 1: highs=%0d pending=%0d", h, p);
    check_int("upd_cur_highs", h, 4);
    check_int("upd_cur_pending", p, 8);
    run_period(-1, 16'd0, h, p, e, pat, pat_n);
    $display("update period 2: highs=%0d pending=%0d", h, p);
    check_int("upd_next_highs", h, 7);
    check_int("upd_next_pending", p, 0);

    // Asynchronous reset at count 5 with a reload pending.
    configure(2'd0, 16'd4, 16'd0, 1'b0, 1'b0);
    cycle(); cycle();
    bus.compare1 = 16'd8; bus.update = 1'b1;
    cycle(); cycle(); cycle();
    check_bit("pending_before_reset", bus.update_pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_rst_pwm_out", bus.pwm_out, 1'b0);
    check_bit("async_rst_period_end", bus.period_end, 1'b0);
    check_bit("async_rst_pending", bus.update_pending, 1'b0);
    $display("reset at count %0d: pwm=%0d pending=%0d", bus.count_val,
             bus.pwm_out, bus.update_pending);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.count_val = next_count(bus.count_val);
    cycle();
    check_bit("reload_after_reset", bus.pwm_out, 1'b1);

    // en dropping on the boundary cycle: no period_end, output low.
    configure(2'd0, 16'd4, 16'd0, 1'b0, 1'b0);
    bus.en = 1'b0;
    cycle();
    check_bit("en_fall_period_end", bus.period_end, 1'b0);
    check_bit("en_fall_pwm_out", bus.pwm_out, 1'b0);

`ifdef PWM_COMPLEMENT_EN
    // Dead time 2, c1=4: out high at counts 2..3, out_n high at 6..9.
    bus.deadtime = 8'd2;
    configure(2'd0, 16'd4, 16'd0, 1'b0, 1'b0);
    run_period(-1, 16'd0, h, p, e, pat, pat_n);
    $display("deadtime 2: pwm=%b pwm_n=%b", pat[9:0], pat_n[9:0]);
    check_int("dt_pwm_pattern", int'(pat[9:0]), 32'h00C);
    check_int("dt_pwm_n_pattern", int'(pat_n[9:0]), 32'h3C0);
    // A 3-cycle high level with dead time 5 never reaches the output.
    bus.deadtime = 8'd5;
    configure(2'd0, 16'd3, 16'd0, 1'b0, 1'b0);
    run_period(-1, 16'd0, h, p, e, pat, pat_n);
    $display("short pulse: pwm=%b pwm_n=%b", pat[9:0], pat_n[9:0]);
    check_int("short_pulse_highs", h, 0);
    check_int("short_pulse_n_pattern", int'(pat_n[9:0]), 32'h300);
`endif

    // Randomized segments checked cycle by cycle against the model.
    for (int s = 0; s < 30; s++) begin
      int bad0 = n_bad;
      bus.en = 1'b0;
      cycle(); cycle();
      bus.period     = 16'($urandom_range(2, 20));
      bus.upnotdown  = 1'($urandom_range(0, 1));
      bus.count_val  = 16'($urandom_range(0, int'(bus.period) - 1));
      bus.align_mode = 2'($urandom_range(0, 3));
      bus.compare1   = 16'($urandom_range(0, int'(bus.period) + 2));
      bus.compare2   = 16'($urandom_range(0, int'(bus.period) + 2));
      bus.invert     = 1'($urandom_range(0, 1));
`ifdef PWM_COMPLEMENT_EN
      bus.deadtime   = 8'($urandom_range(0, 3));
`endif
      bus.en = 1'b1;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          bus.compare1   = 16'($urandom_range(0, int'(bus.period) + 2));
          bus.compare2   = 16'($urandom_range(0, int'(bus.period) + 2));
          bus.align_mode = 2'($urandom_range(0, 3));
          bus.invert     = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 9) == 0) bus.update = 1'b1;
        if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
        cycle();
      end
      $display("random seg %0d: period=%0d dn=%0d new_errors=%0d", s,
               bus.period, bus.upnotdown, n_bad - bad0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

PWM output stage consuming the timer counter's `count_val`. It compares the running count against double-buffered compare values and drives a registered PWM waveform. Compare values are reloaded only at the counter period boundary, so updates never create glitches or runt pulses. It sits beside the counter in the timer peripheral, and its configuration registers are written through the peripheral register file.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  peripheral clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `count_val`  in  16  running counter value
- `period`  in  16  counter period (same register the counter uses)
- `upnotdown`  in  1  counter direction: 0 = up, 1 = down
- `en`  in  1  PWM enable
- `compare1`  in  16  first compare value (staging)
- `compare2`  in  16  second compare value (staging; range mode only)
- `align_mode`  in  2  0 = left, 1 = right, 2 = range, 3 = reserved
- `invert`  in  1  output polarity (staging)
- `update`  in  1  one-cycle pulse requesting a shadow reload
- `pwm_out`  out  1  PWM output
- `period_end`  out  1  one-cycle pulse at each period boundary
- `update_pending`  out  1  reload requested but not yet applied
- `deadtime`  in  8  dead-time cycles (only with `PWM_COMPLEMENT_EN`)
- `pwm_out_n`  out  1  complementary output (only with `PWM_COMPLEMENT_EN`)

## Operation
- **States:** IDLE and RUN.
  - IDLE→RUN when `en`=1. On this transition, shadows load unconditionally from staging and pending clears.
  - RUN→IDLE when `en`=0. Outputs go to 0 on the next edge. Shadows hold. Pending clears.
- **Boundary detection:** `prev_cnt` registers `count_val` every cycle. A boundary occurs when `count_val != prev_cnt` and `count_val` equals the start value.
  - Start value is 0 when `upnotdown`=0, and `period-1` (16-bit wrap) when `upnotdown`=1.
  - A counter `count_reset` that jumps the count to 0 counts as a boundary in up mode only.
- **Reload:** in RUN, at a boundary where `update_pending`=1 or `update`=1, the shadows (c1, c2, mode, inv) load from staging values sampled in that cycle, and pending clears.
  - An `update` pulse outside a boundary sets pending.
  - Repeated `update` pulses are idempotent.
- **Effective compares:** the staging values in a load cycle; the shadows otherwise. This bypass is used for the output computation.
- **Raw level** (unsigned 16-bit compares):
  - left: `count_val < c1`
  - right: `count_val >= c1`
  - range: `c1 <= count_val < c2`; 0 if `c1 >= c2`
  - reserved: 0
- **Output:** `level = raw ^ inv`, registered. `pwm_out = level` in RUN, 0 in IDLE.
- **Compare edge cases:**
  - left with c1=0: constant 0.
  - left with `c1 >= period`: constant 1.
  - right with c1=0: constant 1.
- **`period_end`:** registered, 1 for exactly one cycle after each boundary in RUN.

## Timing
- `pwm_out` lags `count_val` by exactly 1 clock.
- `period_end` and the shadow load are visible 1 clock after the boundary cycle.
- The first compare of a new period already uses the reloaded values; there is no period of stale output.
- `update_pending` rises 1 clock after the `update` pulse and falls 1 clock after the boundary that consumes it.
- **Reset** (asynchronous, any time including mid-period):
  - `pwm_out`=0, `pwm_out_n`=0, `period_end`=0, `update_pending`=0.
  - Shadows = 0, `prev_cnt`=0, state IDLE, dead counter = 0.
- `en` falling in the same cycle as a boundary: IDLE wins; no `period_end`, no reload.

## Configuration
- Macro `PWM_COMPLEMENT_EN`.
- **Defined:** adds `deadtime` and `pwm_out_n` plus an 8-bit dead counter.
  - The dead counter loads `deadtime` on every change of `level` and decrements to 0.
  - `pwm_out = level & (dcnt==0)`; `pwm_out_n = ~level & (dcnt==0)`; both are forced to 0 in IDLE.
  - With `deadtime`=0, `pwm_out_n` is the exact complement of `pwm_out` in RUN.
  - A level pulse shorter than `deadtime` never asserts its output.
- **Undefined:** those ports and the dead counter are absent; `pwm_out` follows the Operation section.

## Test plan
- Counter up, period=10, prescale=0, left mode, c1=4, `en`=1: `pwm_out` is high 4 of every 10 cycles, 1 clock behind count; `period_end` every 10 cycles.
- Same setup, write c1=7 with `update` at count 2: current period stays high 4 cycles; next period high 7; `update_pending` is high from count 3 through the boundary.
- Counter down, period=10, range mode, c1=2, c2=6: high while count is 5..2, i.e. 4 cycles per period.
- Left mode, c1=0 → constant 0; c1=10 → constant 1; `invert`=1 with c1=4 → low 4 of 10.
- Assert `rst_n` low at count 5 while pending: all outputs 0 immediately, pending cleared; re-enable loads staging immediately.
- `PWM_COMPLEMENT_EN` defined, `deadtime`=2, c1=4, period=10: `pwm_out` high 2 cycles, both outputs low 2 cycles, `pwm_out_n` high 4 cycles, both low 2 cycles.
